// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: op codes, FSM states, lane enables.
package mem_pkg;

  localparam logic [3:0] MOP_NOP = 4'd0;
  localparam logic [3:0] MOP_LDW = 4'd1;
  localparam logic [3:0] MOP_STW = 4'd2;
  localparam logic [3:0] MOP_LDB = 4'd3;
  localparam logic [3:0] MOP_STB = 4'd4;
  localparam logic [3:0] MOP_LDH = 4'd5;
  localparam logic [3:0] MOP_STH = 4'd6;

  localparam logic [3:0] BE_ALL = 4'b1111;
  localparam logic [3:0] BE_LO  = 4'b0011;
  localparam logic [3:0] BE_HI  = 4'b1100;
  localparam logic [3:0] BE_B0  = 4'b0001;

  typedef enum logic [1:0] {IDLE, SLOT1, SLOT2, DONE} state_e;

  // Codes 7..15 behave as NOP, so only 1..6 start a bus transfer.
  function automatic logic op_active(input logic [3:0] op);
    return (op != MOP_NOP) && (op <= MOP_STH);
  endfunction

  function automatic logic op_load(input logic [3:0] op);
    return (op == MOP_LDW) || (op == MOP_LDB) || (op == MOP_LDH);
  endfunction

  function automatic logic op_store(input logic [3:0] op);
    return (op == MOP_STW) || (op == MOP_STB) || (op == MOP_STH);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering for one memory slot: byte enables, replicated
// store data, zero-extended load extraction. Misalign flag needs MEM_ALIGN_CHECK_EN.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misalign
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    be       = BE_ALL;
    wdata    = sdata;
    ldata    = rdata;
    misalign = 1'b0;
    case (op)
      MOP_LDB, MOP_STB: begin
        be    = BE_B0 << addr;
        wdata = {4{sdata[7:0]}};
        ldata = {24'h0, rdata[{addr, 3'b000} +: 8]};
      end
      MOP_LDH, MOP_STH: begin
        be    = addr[1] ? BE_HI : BE_LO;
        wdata = {2{sdata[15:0]}};
        ldata = {16'h0, rdata[{addr[1], 4'b0000} +: 16]};
      end
      default: ;
    endcase
`ifdef MEM_ALIGN_CHECK_EN
    case (op)
      MOP_LDH, MOP_STH: misalign = addr[0];
      MOP_LDW, MOP_STW: misalign = |addr;
      default: ;
    endcase
`endif
  end

endmodule

// File: rtl/memory_stage.sv
// Post-execute stage: up to two data-memory transfers in order over one
// req/ack bus, then results to write-back. MEM_ALIGN_CHECK_EN enables faults.
module memory_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] r1,
  input  logic [31:0] r2,
  input  logic        cres,
  input  logic [31:0] m_a1,
  input  logic [31:0] m_a2,
  input  logic [3:0]  m_r1_op,
  input  logic [3:0]  m_r2_op,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] q1,
  output logic [31:0] q2,
  output logic        q_cres,
  output logic        fault
);

  state_e      state;
  logic [3:0]  op1, op2;
  logic [31:0] a1, a2;
  logic        idle;
  logic [3:0]  v_op1, v_op2, be1, be2;
  logic [31:0] v_a1, v_a2, v_d1, v_d2, wd1, wd2, ld1, ld2;
  logic        mis1, mis2, act1, act2, sel2;

  assign idle = (state == IDLE);

  // In IDLE the slot views see the incoming operands so the first request can
  // launch on the accept edge; afterwards they see the captured copies. q1/q2
  // hold r1/r2 until a load overwrites them, so they double as store data.
  assign v_op1 = idle ? (cres ? m_r1_op : MOP_NOP) : op1;
  assign v_op2 = idle ? (cres ? m_r2_op : MOP_NOP) : op2;
  assign v_a1  = idle ? m_a1 : a1;
  assign v_a2  = idle ? m_a2 : a2;
  assign v_d1  = idle ? r1 : q1;
  assign v_d2  = idle ? r2 : q2;

  mem_lane_align u_lane1 (
    .op(v_op1), .addr(v_a1[1:0]), .sdata(v_d1), .rdata(mem_rdata),
    .be(be1), .wdata(wd1), .ldata(ld1), .misalign(mis1)
  );

  mem_lane_align u_lane2 (
    .op(v_op2), .addr(v_a2[1:0]), .sdata(v_d2), .rdata(mem_rdata),
    .be(be2), .wdata(wd2), .ldata(ld2), .misalign(mis2)
  );

  assign act1 = op_active(v_op1) && !mis1;
  assign act2 = op_active(v_op2) && !mis2;
  assign sel2 = idle ? !act1 : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      out_valid <= 1'b0;
      q1        <= '0;
      q2        <= '0;
      q_cres    <= 1'b0;
      op1       <= MOP_NOP;
      op2       <= MOP_NOP;
      a1        <= '0;
      a2        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if ((idle && in_valid && (act1 || act2)) || (state == SLOT1 && mem_ack && act2)) begin
        mem_req   <= 1'b1;
        mem_we    <= op_store(sel2 ? v_op2 : v_op1);
        mem_addr  <= sel2 ? {v_a2[31:2], 2'b00} : {v_a1[31:2], 2'b00};
        mem_be    <= sel2 ? be2 : be1;
        mem_wdata <= sel2 ? wd2 : wd1;
      end
      case (state)
        IDLE: if (in_valid) begin
          q1       <= r1;
          q2       <= r2;
          q_cres   <= cres;
          a1       <= m_a1;
          a2       <= m_a2;
          op1      <= act1 ? m_r1_op : MOP_NOP;
          op2      <= act2 ? m_r2_op : MOP_NOP;
          in_ready <= 1'b0;
          if (act1) begin
            state <= SLOT1;
          end else if (act2) begin
            state <= SLOT2;
          end else begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        SLOT1: if (mem_ack) begin
          if (op_load(op1)) q1 <= ld1;
          if (act2) begin
            state <= SLOT2;
          end else begin
            state     <= DONE;
            mem_req   <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        SLOT2: if (mem_ack) begin
          if (op_load(op2)) q2 <= ld2;
          state     <= DONE;
          mem_req   <= 1'b0;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic fault_pend, to_done;

  assign to_done = (idle && in_valid && !act1 && !act2) ||
                   (state == SLOT1 && mem_ack && !act2) ||
                   (state == SLOT2 && mem_ack);

  // A faulting slot was squashed at accept; its flag waits for DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_pend <= 1'b0;
      fault      <= 1'b0;
    end else begin
      if (idle && in_valid) fault_pend <= mis1 || mis2;
      if (to_done) fault <= idle ? (mis1 || mis2) : fault_pend;
      else if (state == DONE && out_ready) fault <= 1'b0;
    end
  end
`else
  assign fault = 1'b0;
`endif

endmodule
